// File: rtl/tc_pkg.sv
// Shared types and constants for the row control chain and its tile sequencer.
// Pure declarations: no latency and no backpressure of its own.
// Consumers import it so that state encodings and command fields stay consistent.
package tc_pkg;
    localparam int ROWS_DEFAULT   = 8;
    localparam int ADDR_W_DEFAULT = 32;
    localparam int K_W_DEFAULT    = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } seq_state_t;

    typedef struct packed {
        logic [ADDR_W_DEFAULT-1:0] base_addr;
        logic [ADDR_W_DEFAULT-1:0] stride;
        logic [K_W_DEFAULT-1:0]    k_len;
    } tile_cmd_t;
endpackage

// File: rtl/addr_gen.sv
// Accumulating read-address generator and beat counter for the tile sequencer.
// Latency: addr/idx are registered and update one cycle after load or advance.
// Backpressure: when neither load nor advance is high, addr and idx hold.
module addr_gen
    import tc_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int K_W    = K_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              advance,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] stride,
    output logic [ADDR_W-1:0] addr,
    output logic [K_W-1:0]    idx
);
    logic [ADDR_W-1:0] stride_q;

    // Load takes precedence; the adder wraps naturally modulo 2^ADDR_W.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr     <= '0;
            idx      <= '0;
            stride_q <= '0;
        end else if (load) begin
            addr     <= base_addr;
            idx      <= '0;
            stride_q <= stride;
        end else if (advance) begin
            addr     <= addr + stride_q;
            idx      <= idx + K_W'(1);
        end
    end
endmodule

// File: rtl/systolic_seq.sv
// Tile sequencer: issues one SRAM read beat per cycle into the row control chain head.
// Latency: first beat one cycle after accept; done DRAIN_CYC+1 cycles after the last beat.
// Backpressure: stall high suppresses the next beat and holds address/index.
module systolic_seq
    import tc_pkg::*;
#(
    parameter int ROWS      = ROWS_DEFAULT,
    parameter int ADDR_W    = ADDR_W_DEFAULT,
    parameter int K_W       = K_W_DEFAULT,
    parameter int DRAIN_CYC = 2 * ROWS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] stride,
    input  logic [K_W-1:0]    k_len,
    input  logic              stall,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              en,
    output logic              cmen,
    output logic [ADDR_W-1:0] rdaddr,
    output logic [K_W-1:0]    beat_idx
);
    localparam int DC_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [K_W-1:0] K_ONE = K_W'(1);

    seq_state_t      state, state_n;
    logic [DC_W-1:0] drain_cnt, drain_n;
    logic [K_W-1:0]  k_q, k_n;
    logic            en_n, cmen_n, done_n;
    logic            load, advance;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            drain_cnt <= '0;
            k_q       <= '0;
            en        <= 1'b0;
            cmen      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            drain_cnt <= drain_n;
            k_q       <= k_n;
            en        <= en_n;
            cmen      <= cmen_n;
            done      <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        drain_n = drain_cnt;
        k_n     = k_q;
        en_n    = 1'b0;
        cmen_n  = 1'b0;
        done_n  = 1'b0;
        load    = 1'b0;
        advance = 1'b0;
        case (state)
            IDLE: begin
                // Beat 0 goes out on the accept edge itself.
                if (start && !abort) begin
                    if (k_len != '0) begin
                        load    = 1'b1;
                        k_n     = k_len;
                        en_n    = 1'b1;
                        cmen_n  = (k_len == K_ONE);
                        state_n = ISSUE;
                    end else begin
                        done_n = 1'b1;
                    end
                end
            end
            ISSUE: begin
                // beat_idx is the last beat already on the outputs.
                if (abort) begin
                    state_n = IDLE;
                end else if (beat_idx == k_q - K_ONE) begin
                    state_n = DRAIN;
                    drain_n = DC_W'(DRAIN_CYC - 1);
                end else if (!stall) begin
                    advance = 1'b1;
                    en_n    = 1'b1;
                    cmen_n  = (beat_idx + K_ONE == k_q - K_ONE);
                end
            end
            DRAIN: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (drain_cnt == '0) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else begin
                    drain_n = drain_cnt - DC_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    addr_gen #(
        .ADDR_W (ADDR_W),
        .K_W    (K_W)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .advance   (advance),
        .base_addr (base_addr),
        .stride    (stride),
        .addr      (rdaddr),
        .idx       (beat_idx)
    );

    assign busy = (state != IDLE);
endmodule

// File: doc/systolic_seq.md
# systolic_seq

Tile sequencer that drives the 8-stage row control chain in front of the PE array. It accepts one tile command: base address, beat count and address stride. It issues one SRAM read beat per cycle as a registered `en`/`cmen`/`rdaddr` stream into the head of the chain, and honours a stall from the SRAM side. After the last beat it waits for the chain and array to drain, then pulses `done`. It is the sole master of the chain's head inputs.

## Interface
- `ROWS`, default 8: depth of the control chain / PE rows.
- `ADDR_W`, default 32: read-address width.
- `K_W`, default 16: beat-count width.
- `DRAIN_CYC`, default 2*ROWS: cycles waited after the last beat before `done`.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  command strobe; sampled only in IDLE.
- `base_addr`  in  ADDR_W  first read address; latched on accept.
- `stride`  in  ADDR_W  address increment per beat; latched on accept.
- `k_len`  in  K_W  number of beats; latched on accept.
- `stall`  in  1  SRAM not ready; when high, no beat is issued in the following cycle.
- `abort`  in  1  synchronous cancel, valid in any state.
- `busy`  out  1  high in ISSUE and DRAIN.
- `done`  out  1  one-cycle completion pulse.
- `en`  out  1  beat valid, to the head of the chain.
- `cmen`  out  1  commit marker, high with `en` on the final beat only.
- `rdaddr`  out  ADDR_W  read address of the current beat.
- `beat_idx`  out  K_W  index of the current beat (debug/verification).

## Operation
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE, `start`=1, `k_len`≠0: latch the command, clear the beat counter, go to ISSUE.
- IDLE, `start`=1, `k_len`=0: stay in IDLE, pulse `done` next cycle, issue no beat.
- ISSUE, each cycle with `stall`=0: issue beat i on the registered outputs the next cycle.
  - `en`=1, `rdaddr`=base + i*stride, `beat_idx`=i, `cmen`=(i==k_len-1).
  - `rdaddr` is formed by an accumulating adder, not a multiplier, and wraps modulo 2^ADDR_W.
- ISSUE, cycle with `stall`=1: the next cycle has `en`=0 and `cmen`=0. `rdaddr` and `beat_idx` hold. The counter does not advance.
- When the last beat is issued, go to DRAIN and load the drain counter with DRAIN_CYC-1.
- DRAIN: decrement the counter each cycle. At 0, go to IDLE and pulse `done` in the cycle IDLE is entered. `stall` is ignored in DRAIN.
- `abort`=1 in ISSUE or DRAIN:
  - go to IDLE next cycle;
  - `en` and `cmen` are 0 from the next cycle;
  - no `done` pulse.
- `abort`=1 in IDLE: no effect, and any same-cycle `start` is dropped.
- `abort` has priority over `start`.
- `start` outside IDLE is ignored; commands are not queued.

## Timing
- Reset values (asynchronous, while `rst`=0): state=IDLE; `busy`, `done`, `en`, `cmen` = 0; `rdaddr`, `beat_idx` = 0; all latched command fields = 0.
- All outputs are registered; none depends combinationally on an input.
- Accept at cycle t → `busy`=1 at t+1. With no stall, beats appear at t+1 … t+k_len.
- `busy` rises in the first cycle of ISSUE and falls in the cycle `done` pulses.
- Stall: `stall` sampled high at cycle c → `en`=0 at c+1. Each stalled cycle extends ISSUE by exactly one cycle.
- No stall: `done` at t+k_len+DRAIN_CYC+1.
- A new `start` is accepted in the `done` cycle (back-to-back tiles). It gives exactly DRAIN_CYC+1 idle cycles of `en` between tiles.
- Reset mid-operation: outputs go to reset values immediately. Operation resumes in IDLE after `rst` deasserts; no `done` is generated.
- `k_len`=1: the single beat has `en`=1 and `cmen`=1 in the same cycle.

## Structure
- Shared package `tc_pkg`:
  - `seq_state_t` enum (IDLE, ISSUE, DRAIN);
  - `tile_cmd_t` struct {base_addr, stride, k_len};
  - constants ROWS_DEFAULT=8 and ADDR_W_DEFAULT=32, reused by the control chain.
- One natural sub-module: `addr_gen`. It holds the accumulating base+stride register and the beat counter, with load, advance and hold inputs. The FSM stays in `systolic_seq`.

## Test plan
- Basic tile: base=0x100, stride=4, k_len=3, no stall → `rdaddr` 0x100, 0x104, 0x108 on three consecutive `en` cycles; `cmen` only with 0x108; `done` 16+1 cycles after the last beat.
- Stall: k_len=4 with `stall` high for 2 cycles after beat 1 → exactly 2 `en`=0 gap cycles with `rdaddr` held at beat 1's address; beats 2–3 follow; `done` is delayed by 2 cycles.
- Wrap: base=0xFFFF_FFF8, stride=8, k_len=2 → `rdaddr` 0xFFFF_FFF8 then 0x0000_0000.
- Zero and one: k_len=0 → `done` the next cycle, no `en`. k_len=1 → one beat with `en`=`cmen`=1.
- Abort and reset: `abort` at beat 2 of 5 → `en`=0 the next cycle, no `done`, `busy`=0. Repeat with `rst` pulled low mid-DRAIN → all outputs 0 immediately.
- Back-to-back: `start` held high through the `done` cycle → the second tile's first `en` arrives one cycle after `done`, with the second tile's base address.
